// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch control front end and its surroundings:
// raw push-button levels in, count-enable/clear pulses and status out.
interface stopwatch_ctrl_if;
  logic KEY_START;
  logic KEY_CLEAR;
  logic tick_o;
  logic clr_o;
  logic running_o;
  logic paused_o;

  modport master (
    input  KEY_START,
    input  KEY_CLEAR,
    output tick_o,
    output clr_o,
    output running_o,
    output paused_o
  );

  modport slave (
    output KEY_START,
    output KEY_CLEAR,
    input  tick_o,
    input  clr_o,
    input  running_o,
    input  paused_o
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: key synchroniser/debouncer, IDLE/RUN/PAUSE FSM
// and a prescaler that issues the count-enable tick for the BCD seconds counter.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic              CLOCK_50,
  input logic              RESET,
  stopwatch_ctrl_if.master sw
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Bit 0 is the start/stop key, bit 1 the clear key.
  logic [1:0]    key_raw;
  logic [1:0]    key_sync1;
  logic [1:0]    key_sync2;
  logic [1:0]    key_stable;
  logic [1:0]    key_stable_d;
  logic [CW-1:0] db_cnt [2];
  logic [1:0]    key_press;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic          tick_q;
  logic          clr_q;
  logic          running_q;
  logic          paused_q;

  assign key_raw = {sw.KEY_CLEAR, sw.KEY_START};

  // Synchroniser and debounce stage
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_sync1    <= '1;
      key_sync2    <= '1;
      key_stable   <= '1;
      key_stable_d <= '1;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      key_sync1    <= key_raw;
      key_sync2    <= key_sync1;
      key_stable_d <= key_stable;
      for (int i = 0; i < 2; i++) begin
        if (key_sync2[i] != key_stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            key_stable[i] <= key_sync2[i];
            db_cnt[i]     <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A press is the cycle right after the debounced level falls; releases are ignored.
  assign key_press = key_stable_d & ~key_stable;

  always_comb begin
    state_nxt = state;
    if (key_press[1]) begin
      state_nxt = IDLE;
    end else if (key_press[0]) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM and prescaler stage; the tick decision uses the current state so a
  // terminal count coinciding with leaving RUN still fires.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= IDLE;
      presc     <= '0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state)
        RUN: begin
          if (presc == PRE_LAST) begin
            presc  <= '0;
            tick_q <= 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE:   presc <= presc;
        default: presc <= '0;
      endcase
      state     <= state_nxt;
      clr_q     <= key_press[1];
      running_q <= (state_nxt == RUN);
      paused_q  <= (state_nxt == PAUSE);
    end
  end

  assign sw.tick_o    = tick_q;
  assign sw.clr_o     = clr_q;
  assign sw.running_o = running_q;
  assign sw.paused_o  = paused_q;

endmodule
